// File: rtl/ahf_sw_input_conditioner.sv
// ahf_sw_input_conditioner: synchronise, debounce and edge-detect board switches, handing stable values to the CPU via valid/ack.
// Optional macro SW_COND_IRQ_EN adds a registered Irq output gated by IRQ_MASK.
module ahf_sw_input_conditioner #(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 16
`ifdef SW_COND_IRQ_EN
    ,
    parameter logic [WIDTH-1:0] IRQ_MASK = '1
`endif
) (
    input  logic             CLOCK_50,
    input  logic             Reset,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] SW_clean,
    output logic [WIDTH-1:0] SW_rise,
    output logic [WIDTH-1:0] SW_data,
    output logic             SW_valid,
    input  logic             SW_ack,
    output logic             SW_ovf
`ifdef SW_COND_IRQ_EN
    ,
    output logic             Irq
`endif
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0] s1_q, s2_q, cand_q, cand_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] clean_q, clean_d, rise_q, rise_d, data_q, data_d;
    logic             valid_q, valid_d, ovf_q, ovf_d;
    logic             acc, take;

    // Any change in the synchronised value restarts the stability count.
    always_comb begin
        cand_d  = s2_q;
        cnt_d   = (s2_q != cand_q) ? '0 :
                  (cnt_q < CW'(DEBOUNCE_CYCLES)) ? cnt_q + CW'(1) : cnt_q;
        acc     = (s2_q == cand_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) && (cand_q != clean_q);
        take    = SW_ack && valid_q;
        clean_d = acc ? cand_q : clean_q;
        rise_d  = acc ? (cand_q & ~clean_q) : '0;
        data_d  = acc ? cand_q : data_q;
        valid_d = acc || (valid_q && !SW_ack);
        ovf_d   = take ? 1'b0 : (ovf_q || (acc && valid_q));
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            clean_q <= '0;
            rise_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            s1_q    <= SW;
            s2_q    <= s1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign SW_clean = clean_q;
    assign SW_rise  = rise_q;
    assign SW_data  = data_q;
    assign SW_valid = valid_q;
    assign SW_ovf   = ovf_q;

`ifdef SW_COND_IRQ_EN
    logic irq_q, irq_d;

    always_comb irq_d = |(rise_d & IRQ_MASK);

    always_ff @(posedge CLOCK_50) begin
        if (Reset) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end

    assign Irq = irq_q;
`endif
endmodule

// File: tb/tb_ahf_sw_input_conditioner.sv
// tb_ahf_sw_input_conditioner: directed vector bench for the switch conditioner (default DEBOUNCE_CYCLES=16).
module tb_ahf_sw_input_conditioner;
    localparam int W = 5;

    logic         CLOCK_50 = 1'b0;
    logic         Reset    = 1'b1;
    logic         SW_ack   = 1'b0;
    logic [W-1:0] SW       = '0;
    logic [W-1:0] SW_clean, SW_rise, SW_data;
    logic         SW_valid, SW_ovf;
`ifdef SW_COND_IRQ_EN
    logic         Irq;
`endif

    int applied     = 0;
    int miscompares = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    ahf_sw_input_conditioner #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(16)
`ifdef SW_COND_IRQ_EN
        ,
        .IRQ_MASK(5'b00010)
`endif
    ) dut (
        .CLOCK_50(CLOCK_50),
        .Reset(Reset),
        .SW(SW),
        .SW_clean(SW_clean),
        .SW_rise(SW_rise),
        .SW_data(SW_data),
        .SW_valid(SW_valid),
        .SW_ack(SW_ack),
        .SW_ovf(SW_ovf)
`ifdef SW_COND_IRQ_EN
        ,
        .Irq(Irq)
`endif
    );

    typedef struct {
        string        name;
        logic [W-1:0] sw;
        logic         ack;
        int           n;
        logic [W-1:0] clean;
        logic [W-1:0] rise;
        logic [W-1:0] data;
        logic         valid;
        logic         ovf;
    } vec_t;

    vec_t v[25];

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {15'd0, SW_clean, SW_rise, SW_data, SW_valid, SW_ovf};
    endfunction

    function automatic logic [31:0] pack(input logic [W-1:0] c, r, d, input logic vl, o);
        return {15'd0, c, r, d, vl, o};
    endfunction

    initial begin
        v[0]  = '{"glitch_lo",     5'b01010, 1'b0, 10, 5'b11010, 5'b00000, 5'b11010, 1'b1, 1'b0};
        v[1]  = '{"glitch_back",   5'b11010, 1'b0, 30, 5'b11010, 5'b00000, 5'b11010, 1'b1, 1'b0};
        v[2]  = '{"ack",           5'b11010, 1'b1, 1,  5'b11010, 5'b00000, 5'b11010, 1'b0, 1'b0};
        v[3]  = '{"ack_idle",      5'b11010, 1'b1, 1,  5'b11010, 5'b00000, 5'b11010, 1'b0, 1'b0};
        v[4]  = '{"idle",          5'b11010, 1'b0, 1,  5'b11010, 5'b00000, 5'b11010, 1'b0, 1'b0};
        v[5]  = '{"pre_upd1",      5'b11110, 1'b0, 18, 5'b11010, 5'b00000, 5'b11010, 1'b0, 1'b0};
        v[6]  = '{"upd1",          5'b11110, 1'b0, 1,  5'b11110, 5'b00100, 5'b11110, 1'b1, 1'b0};
        v[7]  = '{"hold1",         5'b11110, 1'b0, 61, 5'b11110, 5'b00000, 5'b11110, 1'b1, 1'b0};
        v[8]  = '{"pre_upd2",      5'b01100, 1'b0, 18, 5'b11110, 5'b00000, 5'b11110, 1'b1, 1'b0};
        v[9]  = '{"upd2_ovf",      5'b01100, 1'b0, 1,  5'b01100, 5'b00000, 5'b01100, 1'b1, 1'b1};
        v[10] = '{"hold2",         5'b01100, 1'b0, 61, 5'b01100, 5'b00000, 5'b01100, 1'b1, 1'b1};
        v[11] = '{"ack_ovf",       5'b01100, 1'b1, 1,  5'b01100, 5'b00000, 5'b01100, 1'b0, 1'b0};
        v[12] = '{"idle2",         5'b01100, 1'b0, 1,  5'b01100, 5'b00000, 5'b01100, 1'b0, 1'b0};
        v[13] = '{"upd3",          5'b00001, 1'b0, 19, 5'b00001, 5'b00001, 5'b00001, 1'b1, 1'b0};
        v[14] = '{"rise_clr",      5'b00001, 1'b0, 1,  5'b00001, 5'b00000, 5'b00001, 1'b1, 1'b0};
        v[15] = '{"upd4_fall",     5'b00000, 1'b0, 19, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b1};
        v[16] = '{"pre_upd5",      5'b00011, 1'b0, 18, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b1};
        v[17] = '{"ack_on_acc",    5'b00011, 1'b1, 1,  5'b00011, 5'b00011, 5'b00011, 1'b1, 1'b0};
        v[18] = '{"after_acc",     5'b00011, 1'b0, 1,  5'b00011, 5'b00000, 5'b00011, 1'b1, 1'b0};
        v[19] = '{"pulse16",       5'b00111, 1'b0, 16, 5'b00011, 5'b00000, 5'b00011, 1'b1, 1'b0};
        v[20] = '{"pulse16_end",   5'b00011, 1'b0, 30, 5'b00011, 5'b00000, 5'b00011, 1'b1, 1'b0};
        v[21] = '{"pulse17",       5'b00111, 1'b0, 17, 5'b00011, 5'b00000, 5'b00011, 1'b1, 1'b0};
        v[22] = '{"pulse17_acc",   5'b00011, 1'b0, 2,  5'b00111, 5'b00100, 5'b00111, 1'b1, 1'b1};
        v[23] = '{"return_pre",    5'b00011, 1'b0, 16, 5'b00111, 5'b00000, 5'b00111, 1'b1, 1'b1};
        v[24] = '{"return_acc",    5'b00011, 1'b0, 1,  5'b00011, 5'b00000, 5'b00011, 1'b1, 1'b1};

        SW = 5'b11010;
        step(15);
        check("reset_state", outs(), '0);
        Reset = 1'b0;
        step(18);
        check("release_pre", outs(), '0);
        step(1);
        check("release_acc", outs(), pack(5'b11010, 5'b11010, 5'b11010, 1'b1, 1'b0));
        step(1);
        check("release_rise_clr", outs(), pack(5'b11010, 5'b00000, 5'b11010, 1'b1, 1'b0));

        for (int i = 0; i < 25; i++) begin
            SW     = v[i].sw;
            SW_ack = v[i].ack;
            step(v[i].n);
            check(v[i].name, outs(), pack(v[i].clean, v[i].rise, v[i].data, v[i].valid, v[i].ovf));
        end
        SW_ack = 1'b0;

`ifdef SW_COND_IRQ_EN
        Reset = 1'b1;
        SW    = '0;
        step(2);
        Reset = 1'b0;
        step(20);
        check("irq_idle", {31'd0, Irq}, 32'd0);
        SW = 5'b00010;
        step(18);
        check("irq_pre", {31'd0, Irq}, 32'd0);
        step(1);
        check("irq_pulse", {26'd0, SW_rise, Irq}, {26'd0, 5'b00010, 1'b1});
        step(1);
        check("irq_clr", {31'd0, Irq}, 32'd0);
        SW = 5'b10010;
        step(19);
        check("irq_masked", {26'd0, SW_rise, Irq}, {26'd0, 5'b10000, 1'b0});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
